// File: rtl/ps2_scancode_assembler.sv
// ps2_scancode_assembler
// Folds the raw PS/2 byte stream into 16-bit scancodes with a make/break flag.
// It handles the E0 extended prefix, the F0 break prefix, the 8-byte Pause
// sequence, line-error bytes (00/FF) and an idle timeout inside partial
// sequences.
module ps2_scancode_assembler #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [15:0] scancode,
   output logic        code_valid,
   output logic        is_break,
   output logic        error,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GOT_E0   = 3'd1,
      GOT_F0   = 3'd2,
      GOT_E0F0 = 3'd3,
      PAUSE    = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [15:0]   scancode_q;
   logic          is_break_q, code_valid_q, error_q, busy_q;

   logic          emit, emit_brk, err;
   logic [15:0]   emit_code;
   logic          b_err, b_pfx;

   assign b_err = (byte_in == 8'h00) || (byte_in == 8'hFF);
   assign b_pfx = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);

   // Next-state: byte decode per state, else idle-timeout accounting.
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      tcnt_d    = tcnt_q;
      emit      = 1'b0;
      emit_brk  = 1'b0;
      emit_code = 16'h0000;
      err       = 1'b0;
      if (byte_valid) begin
         // A byte always beats a timeout firing in the same cycle.
         tcnt_d = '0;
         case (state_q)
            IDLE: begin
               if (b_err)                 err = 1'b1;
               else if (byte_in == 8'hE0) state_d = GOT_E0;
               else if (byte_in == 8'hF0) state_d = GOT_F0;
               else if (byte_in == 8'hE1) begin
                  state_d = PAUSE;
                  skip_d  = 3'd7;
               end else begin
                  emit      = 1'b1;
                  emit_code = {8'h00, byte_in};
               end
            end
            GOT_E0: begin
               if (b_err || byte_in == 8'hE1) begin
                  err     = 1'b1;
                  state_d = IDLE;
               end else if (byte_in == 8'hF0) state_d = GOT_E0F0;
               else if (byte_in == 8'hE0)     state_d = GOT_E0;
               else begin
                  emit      = 1'b1;
                  emit_code = {8'hE0, byte_in};
                  state_d   = IDLE;
               end
            end
            GOT_F0, GOT_E0F0: begin
               state_d = IDLE;
               if (b_err || b_pfx) err = 1'b1;
               else begin
                  emit      = 1'b1;
                  emit_brk  = 1'b1;
                  emit_code = {(state_q == GOT_E0F0) ? 8'hE0 : 8'h00, byte_in};
               end
            end
            PAUSE: begin
               // Pause bytes are skipped blindly, line-error codes included.
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  emit      = 1'b1;
                  emit_code = 16'hE114;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (tcnt_q == TLAST) begin
            err     = 1'b1;
            state_d = IDLE;
            tcnt_d  = '0;
         end else begin
            tcnt_d = tcnt_q + TW'(1);
         end
      end
   end

   // State, counters and registered outputs; code fields only load on emit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         skip_q       <= 3'd0;
         tcnt_q       <= '0;
         scancode_q   <= 16'h0000;
         is_break_q   <= 1'b0;
         code_valid_q <= 1'b0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         skip_q       <= skip_d;
         tcnt_q       <= tcnt_d;
         code_valid_q <= emit;
         error_q      <= err;
         busy_q       <= (state_d != IDLE);
         if (emit) begin
            scancode_q <= emit_code;
            is_break_q <= emit_brk;
         end
      end
   end

   assign scancode   = scancode_q;
   assign is_break   = is_break_q;
   assign code_valid = code_valid_q;
   assign error      = error_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_scancode_assembler.sv
// Bench for ps2_scancode_assembler: directed test-plan steps followed by
// random byte streams, checked every cycle against a sequence-level model.
module tb_ps2_scancode_assembler;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic [15:0] scancode;
   logic        code_valid, is_break, error, busy;

   int n_pass = 0;
   int n_tot  = 0;

   // Model: bytes of the pending prefix, pause bytes still to skip, idle run.
   logic [7:0]  pfx[$];
   int          pause_left;
   int          idle;
   logic [15:0] e_sc;
   logic        e_brk, e_cv, e_err, e_busy;

   ps2_scancode_assembler #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .resetn(resetn), .byte_in(byte_in), .byte_valid(byte_valid),
      .scancode(scancode), .code_valid(code_valid), .is_break(is_break),
      .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic bit has(input logic [7:0] q[$], input logic [7:0] v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      pfx.delete();
      pause_left = 0; idle = 0;
      e_sc = 16'h0000; e_brk = 1'b0; e_cv = 1'b0; e_err = 1'b0; e_busy = 1'b0;
   endtask

   task automatic fail_seq();
      e_err = 1'b1;
      pfx.delete();
   endtask

   task automatic emit(input logic [15:0] c, input logic b);
      e_cv = 1'b1; e_sc = c; e_brk = b;
      pfx.delete();
   endtask

   // One cycle of the reference model: what the outputs should be after the edge.
   task automatic model_step(input logic v, input logic [7:0] b);
      bit in_seq;
      in_seq = (pfx.size() > 0) || (pause_left > 0);
      e_cv = 1'b0; e_err = 1'b0;
      if (!v) begin
         if (in_seq) begin
            idle++;
            if (idle == T) begin
               fail_seq();
               pause_left = 0; idle = 0;
            end
         end
      end else begin
         idle = 0;
         if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) emit(16'hE114, 1'b0);
         end else if (b == 8'h00 || b == 8'hFF) fail_seq();
         else if (b == 8'hE1) begin
            if (pfx.size() == 0) pause_left = 7;
            else fail_seq();
         end else if (b == 8'hE0 || b == 8'hF0) begin
            if (has(pfx, 8'hF0)) fail_seq();
            else pfx.push_back(b);
         end else
            emit({has(pfx, 8'hE0) ? 8'hE0 : 8'h00, b}, has(pfx, 8'hF0));
      end
      e_busy = (pfx.size() > 0) || (pause_left > 0);
   endtask

   task automatic check_all(input string tag);
      n_tot++;
      assert (scancode === e_sc) n_pass++;
      else $error("FAIL %s scancode got %h want %h", tag, scancode, e_sc);
      n_tot++;
      assert (is_break === e_brk) n_pass++;
      else $error("FAIL %s is_break got %b want %b", tag, is_break, e_brk);
      n_tot++;
      assert (code_valid === e_cv) n_pass++;
      else $error("FAIL %s code_valid got %b want %b", tag, code_valid, e_cv);
      n_tot++;
      assert (error === e_err) n_pass++;
      else $error("FAIL %s error got %b want %b", tag, error, e_err);
      n_tot++;
      assert (busy === e_busy) n_pass++;
      else $error("FAIL %s busy got %b want %b", tag, busy, e_busy);
   endtask

   task automatic cyc(input logic v, input logic [7:0] b, input string tag);
      byte_valid = v;
      byte_in    = v ? b : 8'($urandom);
      @(posedge clk);
      #1;
      model_step(v, b);
      check_all(tag);
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      cyc(1'b1, b, tag);
   endtask

   task automatic idle_n(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, tag);
   endtask

   task automatic do_reset(input string tag);
      resetn = 1'b0; byte_valid = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      check_all(tag);
      resetn = 1'b1;
   endtask

   initial begin
      logic [7:0] pause_seq [8];
      logic [7:0] b;
      int r;
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      model_reset();

      do_reset("reset");
      idle_n(2, "post_reset");

      // plain make, extended make, extended break back-to-back
      send(8'h1C, "mk"); send(8'hE0, "mk"); send(8'h75, "emk");
      send(8'hE0, "ebk"); send(8'hF0, "ebk"); send(8'h6B, "ebk");
      idle_n(2, "gap");

      // plain break then arrow
      send(8'hF0, "bk"); send(8'h1C, "bk"); send(8'hE0, "arrow"); send(8'h72, "arrow");
      idle_n(2, "gap");

      // pause, including F0/E1 bytes inside it
      foreach (pause_seq[i]) send(pause_seq[i], "pause");
      idle_n(2, "gap");

      // protocol errors keep prior scancode
      send(8'hF0, "err1"); send(8'hE0, "err1");
      send(8'hE0, "err2"); send(8'hFF, "err2");
      idle_n(2, "gap");

      // timeout fires, then a byte landing on the would-fire cycle wins
      send(8'hE0, "toA"); idle_n(T + 2, "toA");
      send(8'hE0, "toB"); idle_n(T - 1, "toB"); send(8'h75, "toB");
      idle_n(2, "gap");

      // reset mid-sequence
      send(8'hE0, "rst_mid"); send(8'hF0, "rst_mid");
      do_reset("rst_mid");
      send(8'h74, "rst_mid"); idle_n(2, "gap");

      // random streams, weighted toward prefixes and with gaps near the timeout
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 11);
         case (r)
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = 8'hE1;
            5:       b = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            default: b = 8'($urandom_range(1, 254));
         endcase
         send(b, "rand");
         r = $urandom_range(0, 19);
         if (r >= 17)      idle_n($urandom_range(T - 2, T + 2), "rand_gap");
         else if (r >= 12) idle_n($urandom_range(1, 3), "rand_gap");
         if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
